// File: rtl/tpu_pkg.sv
// Shared definitions for the tile sequencer: state encoding, default sizes
// and a small helper used by the optional watchdog.
package tpu_pkg;

  localparam int DEFAULT_WIDTH_HEIGHT   = 16;
  localparam int DEFAULT_TILE_WIDTH     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 64 * DEFAULT_WIDTH_HEIGHT;
  localparam int WATCHDOG_WIDTH         = 16;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD_W   = 3'd1,
    ST_WAIT_W   = 3'd2,
    ST_FEED     = 3'd3,
    ST_WAIT_OUT = 3'd4,
    ST_NEXT     = 3'd5,
    ST_FINISH   = 3'd6
  } seq_state_t;

  function automatic logic is_wait_state(input seq_state_t s);
    return (s == ST_WAIT_W) || (s == ST_WAIT_OUT);
  endfunction

endpackage

// File: rtl/tpu_sequencer_if.sv
// Job/handshake bundle between the tile sequencer (slave) and the job issuer
// plus downstream loader/reader/writer blocks (master).
interface tpu_sequencer_if
  import tpu_pkg::*;
#(
  parameter int TILE_WIDTH = DEFAULT_TILE_WIDTH
);

  logic                  start;
  logic [TILE_WIDTH-1:0] num_tiles;
  logic                  wt_load_done;
  logic                  wr_done;
  logic                  busy;
  logic                  done;
  logic                  wt_load_start;
  logic                  rd_active;
  logic                  wt_buf_sel;
  logic [TILE_WIDTH-1:0] tile_idx;
  logic                  error;

  modport slave (
    input  start, num_tiles, wt_load_done, wr_done,
    output busy, done, wt_load_start, rd_active, wt_buf_sel, tile_idx, error
  );

  modport master (
    output start, num_tiles, wt_load_done, wr_done,
    input  busy, done, wt_load_start, rd_active, wt_buf_sel, tile_idx, error
  );

endinterface

// File: rtl/tpu_sequencer_seq_watchdog.sv
// Per-wait-state watchdog: counts cycles while enabled, flags expiry on the
// cycle the limit is reached. Only instantiated under TPU_SEQ_TIMEOUT_EN.
module seq_watchdog
  import tpu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [WATCHDOG_WIDTH-1:0] r_count;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= r_count + WATCHDOG_WIDTH'(1);
    end
  end

  // Count is zero on the first wait cycle, so expiry lands on cycle TIMEOUT_CYCLES.
  assign o_expired = i_enable && (r_count == WATCHDOG_WIDTH'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/tpu_sequencer.sv
// Tile sequencer: per tile, pulses the weight loader, then the read controller,
// and waits for the output writer. Optional watchdog: TPU_SEQ_TIMEOUT_EN.
module tpu_sequencer
  import tpu_pkg::*;
#(
  parameter int WIDTH_HEIGHT   = DEFAULT_WIDTH_HEIGHT,
  parameter int TILE_WIDTH     = DEFAULT_TILE_WIDTH,
  parameter int TIMEOUT_CYCLES = 64 * WIDTH_HEIGHT
) (
  input logic            clk,
  input logic            reset,
  tpu_sequencer_if.slave io_seq
);

  seq_state_t            r_state;
  seq_state_t            w_next;
  logic [TILE_WIDTH-1:0] r_num_tiles;
  logic [TILE_WIDTH-1:0] r_tile_idx;
  logic                  r_buf_sel;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_wt_load_start;
  logic                  r_rd_active;
  logic                  r_error;
  logic                  w_accept;
  logic                  w_advance;
  logic                  w_timeout;
  logic                  w_expired;

`ifdef TPU_SEQ_TIMEOUT_EN
  logic w_in_wait;

  assign w_in_wait = is_wait_state(r_state);

  seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk       (clk),
    .reset     (reset),
    .i_clear   (!w_in_wait),
    .i_enable  (w_in_wait),
    .o_expired (w_expired)
  );
`else
  assign w_expired = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path leaves a
  // variable unassigned and infers a latch.
  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    w_advance = 1'b0;
    w_timeout = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (io_seq.start) begin
          w_accept = 1'b1;
          w_next   = (io_seq.num_tiles == '0) ? ST_FINISH : ST_LOAD_W;
        end
      end
      ST_LOAD_W: w_next = ST_WAIT_W;
      ST_WAIT_W: begin
        if (io_seq.wt_load_done) begin
          w_next = ST_FEED;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_FEED: w_next = ST_WAIT_OUT;
      ST_WAIT_OUT: begin
        if (io_seq.wr_done) begin
          w_next = ST_NEXT;
        end else if (w_expired) begin
          w_timeout = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_NEXT: begin
        if (r_tile_idx == r_num_tiles - TILE_WIDTH'(1)) begin
          w_next = ST_FINISH;
        end else begin
          w_advance = 1'b1;
          w_next    = ST_LOAD_W;
        end
      end
      ST_FINISH: w_next = ST_IDLE;
      default:   w_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so each pulse appears the cycle
  // after the edge that causes it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state         <= ST_IDLE;
      r_num_tiles     <= '0;
      r_tile_idx      <= '0;
      r_buf_sel       <= 1'b0;
      r_busy          <= 1'b0;
      r_done          <= 1'b0;
      r_wt_load_start <= 1'b0;
      r_rd_active     <= 1'b0;
      r_error         <= 1'b0;
    end else begin
      r_state         <= w_next;
      r_busy          <= (w_next != ST_IDLE);
      r_done          <= (w_next == ST_FINISH);
      r_wt_load_start <= (w_next == ST_LOAD_W);
      r_rd_active     <= (w_next == ST_FEED);
      if (w_accept) begin
        r_num_tiles <= io_seq.num_tiles;
        r_tile_idx  <= '0;
        r_buf_sel   <= 1'b0;
        r_error     <= 1'b0;
      end else if (w_advance) begin
        r_tile_idx  <= r_tile_idx + TILE_WIDTH'(1);
        r_buf_sel   <= ~r_buf_sel;
      end
      if (w_timeout) begin
        r_error <= 1'b1;
      end
    end
  end

  assign io_seq.busy          = r_busy;
  assign io_seq.done          = r_done;
  assign io_seq.wt_load_start = r_wt_load_start;
  assign io_seq.rd_active     = r_rd_active;
  assign io_seq.wt_buf_sel    = r_buf_sel;
  assign io_seq.tile_idx      = r_tile_idx;
  assign io_seq.error         = r_error;

endmodule

// File: tb/tb_tpu_sequencer.sv
// Self-checking bench for tpu_sequencer: vector table, corner sequences and
// randomized jobs against a cycle-count model of the tile schedule.
module tb_tpu_sequencer;

  localparam int TW = 8;

  typedef struct {
    int n;
    int d1;
    int d2;
    bit strays;
    int exp_done;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   d1_q[$];
  int   d2_q[$];

  tpu_sequencer_if #(.TILE_WIDTH(TW)) seq_if();

  tpu_sequencer #(
    .WIDTH_HEIGHT   (16),
    .TILE_WIDTH     (TW),
    .TIMEOUT_CYCLES (64)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .io_seq (seq_if)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, "_busy"}, seq_if.busy, 0);
    check({tag, "_done"}, seq_if.done, 0);
    check({tag, "_wt_load_start"}, seq_if.wt_load_start, 0);
    check({tag, "_rd_active"}, seq_if.rd_active, 0);
    check({tag, "_wt_buf_sel"}, seq_if.wt_buf_sel, 0);
    check({tag, "_tile_idx"}, seq_if.tile_idx, 0);
    check({tag, "_error"}, seq_if.error, 0);
  endtask

  // p counts edges after the accepting edge; observation is 1 time unit after
  // each edge. Loader/writer responses are driven d1/d2 wait cycles after the
  // corresponding pulse, taken from d1_q/d2_q per tile.
  task automatic run_job(input int n, input int exp_done, input bit strays);
    int wl_cnt = 0, rd_cnt = 0, done_cnt = 0;
    int done_p = -1, end_p = -1, last_wr = -100, last_wl = -100;
    int wt_due = -1, wr_due = -1, d;
    bit wt_pending = 1'b0;
    bit stray_now;
    seq_if.num_tiles = TW'(n);
    seq_if.start     = 1'b1;
    tick();
    seq_if.start = 1'b0;
    for (int p = 0; p < exp_done + 64; p++) begin
      if (p > 0) tick();
      if (p > 0 && !seq_if.busy) begin
        end_p = p;
        break;
      end
      if (seq_if.wt_load_start) begin
        check("tile_idx_at_load", seq_if.tile_idx, wl_cnt);
        check("buf_sel_at_load", seq_if.wt_buf_sel, wl_cnt % 2);
        d = (wl_cnt < d1_q.size()) ? d1_q[wl_cnt] : 1;
        wt_due     = p + d;
        wt_pending = 1'b1;
        last_wl    = p;
        wl_cnt++;
      end
      if (seq_if.rd_active) begin
        d = (rd_cnt < d2_q.size()) ? d2_q[rd_cnt] : 1;
        wr_due = p + d;
        rd_cnt++;
      end
      if (seq_if.done) begin
        done_cnt++;
        done_p = p;
        check("tile_idx_at_done", seq_if.tile_idx, (n > 0) ? n - 1 : 0);
      end
      stray_now = strays && wt_pending && (p > last_wl) &&
                  ((p == last_wl + 1) || ($urandom_range(0, 3) == 0));
      seq_if.wt_load_done = (p == wt_due);
      if (p == wt_due) wt_pending = 1'b0;
      seq_if.wr_done = (p == wr_due) || stray_now;
      if (p == wr_due) last_wr = p;
      seq_if.start = seq_if.busy &&
                     (stray_now || (strays && ((p == wr_due) || ($urandom_range(0, 7) == 0))));
      if (seq_if.start) seq_if.num_tiles = TW'($urandom_range(0, 255));
    end
    seq_if.start        = 1'b0;
    seq_if.wt_load_done = 1'b0;
    seq_if.wr_done      = 1'b0;
    check("job_terminated", end_p >= 0, 1);
    check("done_count", done_cnt, 1);
    check("done_cycle", done_p, exp_done);
    check("busy_fall", end_p, done_p + 1);
    check("wt_load_start_count", wl_cnt, n);
    check("rd_active_count", rd_cnt, n);
    if (n > 0) check("done_after_wr_done", done_p, last_wr + 2);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "bench timeout");
  end

  initial begin
    vec_t vecs[5];
    int   n, exp, d1, d2, cnt, err_p, done_seen, err_seen;
    bit   strays;

    vecs[0] = '{n: 1,   d1: 5, d2: 40, strays: 1'b0, exp_done: 48};
    vecs[1] = '{n: 3,   d1: 2, d2: 3,  strays: 1'b0, exp_done: 24};
    vecs[2] = '{n: 0,   d1: 1, d2: 1,  strays: 1'b0, exp_done: 0};
    vecs[3] = '{n: 2,   d1: 4, d2: 2,  strays: 1'b1, exp_done: 18};
    vecs[4] = '{n: 255, d1: 1, d2: 1,  strays: 1'b0, exp_done: 1275};

    seq_if.start        = 1'b1;
    seq_if.num_tiles    = TW'(3);
    seq_if.wt_load_done = 1'b0;
    seq_if.wr_done      = 1'b0;
    reset               = 1'b1;

    // Reset with start held high: nothing may leave the reset state.
    for (int i = 0; i < 3; i++) tick();
    check_idle_outputs("in_reset");
    reset        = 1'b0;
    seq_if.start = 1'b0;
    tick();
    tick();
    check_idle_outputs("after_reset");

    for (int v = 0; v < 5; v++) begin
      d1_q.delete();
      d2_q.delete();
      for (int t = 0; t < vecs[v].n; t++) begin
        d1_q.push_back(vecs[v].d1);
        d2_q.push_back(vecs[v].d2);
      end
      run_job(vecs[v].n, vecs[v].exp_done, vecs[v].strays);
    end

    // Mid-job reset while waiting on the output writer.
    seq_if.num_tiles = TW'(2);
    seq_if.start     = 1'b1;
    tick();
    seq_if.start = 1'b0;
    check("midreset_load_start", seq_if.wt_load_start, 1);
    tick();
    seq_if.wt_load_done = 1'b1;
    tick();
    seq_if.wt_load_done = 1'b0;
    check("midreset_rd_active", seq_if.rd_active, 1);
    tick();
    tick();
    check("midreset_busy_before", seq_if.busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_idle_outputs("midreset");
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      done_seen += int'(seq_if.done) + int'(seq_if.busy);
    end
    check("midreset_no_done_no_busy", done_seen, 0);

`ifdef TPU_SEQ_TIMEOUT_EN
    // Loader never answers: error and IDLE after 64 cycles in WAIT_W.
    seq_if.num_tiles = TW'(1);
    seq_if.start     = 1'b1;
    tick();
    seq_if.start = 1'b0;
    err_p     = -1;
    done_seen = 0;
    for (int p = 1; p < 200; p++) begin
      tick();
      done_seen += int'(seq_if.done);
      if (seq_if.error) begin
        err_p = p;
        check("wdog_busy_low", seq_if.busy, 0);
        break;
      end
    end
    check("wdog_error_cycle", err_p, 65);
    check("wdog_no_done", done_seen, 0);
    tick();
    check("wdog_error_sticky", seq_if.error, 1);
    seq_if.num_tiles = TW'(0);
    seq_if.start     = 1'b1;
    tick();
    seq_if.start = 1'b0;
    check("wdog_error_cleared", seq_if.error, 0);
    check("wdog_restart_done", seq_if.done, 1);
    tick();
    tick();
`else
    // Without the watchdog the sequencer waits indefinitely.
    seq_if.num_tiles = TW'(1);
    seq_if.start     = 1'b1;
    tick();
    seq_if.start = 1'b0;
    err_seen = 0;
    cnt      = 0;
    for (int p = 1; p < 200; p++) begin
      tick();
      err_seen += int'(seq_if.error);
      cnt      += int'(seq_if.busy);
    end
    check("nowdog_error_zero", err_seen, 0);
    check("nowdog_busy_held", cnt, 199);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
`endif

    // Randomized jobs: done lands after the sum of per-tile periods, each
    // being both wait latencies plus three fixed sequencer cycles.
    for (int j = 0; j < 20; j++) begin
      n      = ($urandom_range(0, 9) == 0) ? 0 : $urandom_range(1, 6);
      strays = 1'($urandom_range(0, 1));
      exp    = 0;
      d1_q.delete();
      d2_q.delete();
      for (int t = 0; t < n; t++) begin
        d1 = $urandom_range(1, 8);
        d2 = $urandom_range(1, 8);
        d1_q.push_back(d1);
        d2_q.push_back(d2);
        exp += d1 + d2 + 3;
      end
      run_job(n, exp, strays);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
